// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Tracks in-flight register writes (EXE/MEM/WB) and raises a
//                combinational stall for RAW hazards that cannot be forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_forward,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_uses_src1,
    input  logic             id_wb_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_mem_read,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_read;
        logic [REG_W-1:0] dest;
    } entry_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    entry_t           r_exe;
    entry_t           r_mem;
    entry_t           r_wb;
    logic [CNT_W-1:0] r_stall_count;

    logic w_raw_exe;
    logic w_raw_mem;
    logic w_hazard;
    logic w_unused_wb;

    function automatic logic f_match(input entry_t e, input logic [REG_W-1:0] s);
        return e.valid & e.wb_en & (e.dest == s);
    endfunction

    assign w_raw_exe = (id_uses_src1 & f_match(r_exe, id_src1)) |
                       (id_two_src   & f_match(r_exe, id_src2));
    assign w_raw_mem = (id_uses_src1 & f_match(r_mem, id_src1)) |
                       (id_two_src   & f_match(r_mem, id_src2));

    // With forwarding only a load in EXE is too late; without it, EXE and MEM
    // both are. WB never blocks: the register file writes on the falling edge.
    assign w_hazard     = enable_forward ? (w_raw_exe & r_exe.mem_read)
                                         : (w_raw_exe | w_raw_mem);
    assign hazard_stall = id_valid & ~flush & w_hazard;
    assign stall_count  = r_stall_count;

    // WB is retained so the full write window stays observable in the state.
    assign w_unused_wb  = ^r_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe         <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_stall_count <= '0;
        end else if (!freeze) begin
            r_wb  <= r_mem;
            r_mem <= r_exe;
            if (hazard_stall | flush | ~id_valid) begin
                r_exe <= '0;
            end else begin
                r_exe <= {1'b1, id_wb_en, id_mem_read, id_dest};
            end
            if (hazard_stall && (r_stall_count != c_cnt_max)) begin
                r_stall_count <= r_stall_count + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the operand forwarding unit in the 5-stage pipeline: EXE, MEM and WB.
- Tracks every in-flight register write from ID through WB in a 3-entry shift pipeline.
- Asserts hazard_stall when an instruction in ID reads a register whose value cannot be supplied in time, either by forwarding or by the register file.
- Also keeps a saturating stall counter for performance measurement.

Parameters:
- REG_W, 4, width of register identifiers.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable_forward  in  1  1 = forwarding paths active (same mode bit fed to the forwarding unit).
- freeze  in  1  memory-wait freeze; whole pipeline holds.
- flush  in  1  taken branch; the instruction in ID is squashed.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_W  first source register.
- id_src2  in  REG_W  second source register.
- id_two_src  in  1  instruction reads id_src2 (store, or register-operand ALU op).
- id_uses_src1  in  1  instruction reads id_src1 (0 for MOV/MVN/branch).
- id_wb_en  in  1  instruction writes a register.
- id_dest  in  REG_W  destination register.
- id_mem_read  in  1  instruction is a load.
- hazard_stall  out  1  hold IF/ID and inject a bubble into EXE.
- stall_count  out  CNT_W  number of cycles hazard_stall was 1 and freeze was 0 (saturating).

Behaviour:
- State: entries E (EXE), M (MEM), W (WB). Each entry holds {valid, wb_en, mem_read, dest}.
- Reset (rst_n=0, async): all entries valid=0, wb_en=0, mem_read=0, dest=0; stall_count=0. hazard_stall is combinational, so it evaluates to 0 after reset.
- Match rule: matchX(s) = X.valid & X.wb_en & (X.dest==s).
- Source used: src1 is used when id_uses_src1=1; src2 is used when id_two_src=1.
- Hazard rule with enable_forward=0:
  - stall = id_valid & ~flush & (any used source matches E or M).
  - W does not cause a stall because the register file writes on the falling edge.
- Hazard rule with enable_forward=1:
  - stall = id_valid & ~flush & (any used source matches E with E.mem_read=1). This is the load-use case only.
  - Matches in M, and non-load matches in E, are forwarded and do not stall.
- hazard_stall is purely combinational from inputs and state: zero latency, same cycle as the ID instruction.
- Update on each rising edge, when freeze=0:
  - W <= M; M <= E.
  - E <= bubble (valid=0) if hazard_stall | flush | ~id_valid.
  - Otherwise E <= {1, id_wb_en, id_mem_read, id_dest}.
- freeze=1: all entries and stall_count hold. freeze has priority over stall and flush.
- stall_count increments when hazard_stall=1 & freeze=0. It saturates at all-ones and never wraps.
- Load-use timing: a stall on a load lasts exactly 1 cycle with forwarding on. With forwarding off, a RAW hazard on the immediately preceding instruction lasts 2 cycles.
- Simultaneous flush and hazard: flush wins; hazard_stall=0 and a bubble enters E.
- dest==src==0 is treated as a real register; there is no zero-register special case.
- Reset asserted mid-stall clears all state immediately. hazard_stall then drops in the same cycle, because all entries become invalid.

Test Plan:
- enable_forward=1; issue load writing R3, then ADD reading R3 as src1 -> hazard_stall=1 for exactly 1 cycle; E holds a bubble next cycle; ADD proceeds; stall_count=1.
- enable_forward=0; issue ADD writing R5, then SUB reading R5 as src2 with id_two_src=1 -> hazard_stall=1 for 2 cycles, then 0; stall_count=2.
- enable_forward=1; ALU op writing R5, then consumer of R5 -> hazard_stall=0 throughout; stall_count=0.
- Load writing R2, then consumer with id_two_src=0 and id_src2=2, src1 not matching -> no stall. Then consumer with id_two_src=1 -> stall.
- Load-use stall active, then freeze=1 held for 3 cycles -> entries and stall_count unchanged. hazard_stall stays 1; the stall resolves 1 cycle after freeze drops.
- Load-use with flush=1 in the same cycle -> hazard_stall=0 and bubble inserted. Separately: force stall_count to all-ones -> further stalls leave it at all-ones. Pull rst_n low mid-stall -> hazard_stall=0 immediately and stall_count=0.
